fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_SEL, default 2'b00, ARF_OutDSel code that routes the PC to the memory address.
REQ-002 SHALL have parameter PC_REGSEL, default 3'b100, ARF_RegSel one-hot code that selects the PC.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port Start  input  1  level request to fetch; held high for continuous fetching.
REQ-006 SHALL have port IROut  input  16  instruction register contents from the datapath.
REQ-007 SHALL have port InstrReady  input  1  downstream decoder accepts Instr.
REQ-008 SHALL have port Mem_CS  output  1  memory chip select; 0 = active.
REQ-009 SHALL have port Mem_WR  output  1  memory write; 0 = read; always 0 from this block.
REQ-010 SHALL have ports IR_LH and IR_Write  output  1 each  IR byte select (0 = low byte, 1 = high byte) and IR write enable.
REQ-011 SHALL have ports ARF_RegSel  output  3, ARF_FunSel  output  2, ARF_OutDSel  output  2  ARF controls; ARF_FunSel 2'b01 = increment.
REQ-012 SHALL have port Instr  output  16  fetched instruction, valid while InstrValid=1.
REQ-013 SHALL have port InstrValid  output  1  handshake valid.
REQ-014 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port FetchCount  output  16  number of completed handshakes; saturates at 16'hFFFF.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH_L, FETCH_H and VALID, plus WAIT_L and WAIT_H when configured.
REQ-017 IDLE SHALL drive Mem_CS=1, IR_Write=0, ARF_RegSel=000, ARF_FunSel=00 and InstrValid=0, and SHALL move to FETCH_L on the edge where Start=1.
REQ-018 FETCH_L SHALL drive Mem_CS=0, ARF_OutDSel=PC_SEL, IR_Write=1, IR_LH=0, ARF_RegSel=PC_REGSEL and ARF_FunSel=01, so that the low byte is captured and the PC increments on the same edge; next state FETCH_H.
REQ-019 FETCH_H SHALL drive the same outputs as FETCH_L except IR_LH=1; next state VALID.
REQ-020 VALID SHALL drive InstrValid=1, Instr=IROut, Mem_CS=1, IR_Write=0 and ARF_RegSel=000.
REQ-021 VALID SHALL hold until InstrReady=1; on that edge FetchCount SHALL increment and the next state SHALL be FETCH_L if Start=1, else IDLE.
REQ-022 Base latency from the Start edge to InstrValid=1 SHALL be 2 cycles, giving back-to-back throughput of one instruction per 3 cycles.
REQ-023 InstrReady SHALL be ignored outside VALID.
REQ-024 Deasserting Start mid-fetch SHALL NOT abort the fetch; the fetch completes to VALID.
REQ-025 Mem_WR SHALL be constant 0.
REQ-026 ARF_OutDSel SHALL be PC_SEL in all states.
REQ-027 Exactly two PC increments SHALL occur per fetch.

Reset
REQ-028 When Reset=0 at a rising edge, state SHALL become IDLE and FetchCount SHALL become 0, with all outputs at IDLE values.
REQ-029 Reset asserted during FETCH_L, FETCH_H or WAIT_* SHALL suppress any increment or IR write in the cycle following the reset edge.

Configuration
REQ-030 Macro FETCH_WAIT_STATE_EN, when defined, SHALL insert WAIT_L before FETCH_L and WAIT_H before FETCH_H.
REQ-031 WAIT_L and WAIT_H SHALL drive Mem_CS=0, IR_Write=0 and ARF_RegSel=000, so that the address settles for one cycle.
REQ-032 With FETCH_WAIT_STATE_EN defined, latency from Start to InstrValid SHALL be 4 cycles.
REQ-033 Without FETCH_WAIT_STATE_EN, the WAIT states SHALL be absent and latency SHALL be 2 cycles.

Verification
REQ-034 Reset=0 for 2 cycles, then 1 -> Busy=0, InstrValid=0, FetchCount=0, Mem_CS=1.
REQ-035 Start pulse, IROut=16'hA55A by the VALID cycle, InstrReady=1 -> InstrValid rises 2 cycles after the Start edge, Instr=16'hA55A, ARF increment pulses=2, FetchCount=1, return to IDLE.
REQ-036 Start held high, InstrReady=1 -> 3 handshakes in 9 cycles, FetchCount=3, IR_LH sequence 0,1 per fetch.
REQ-037 InstrReady=0 for 5 cycles in VALID -> InstrValid stays 1, no Mem_CS=0, no ARF increment, FetchCount unchanged.
REQ-038 Reset=0 asserted in FETCH_H -> next cycle IDLE, IR_Write=0, exactly 1 PC increment total.
REQ-039 FETCH_WAIT_STATE_EN defined -> InstrValid 4 cycles after Start; IR_Write high only in FETCH_L and FETCH_H; FetchCount preset path saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads a 16-bit instruction as two bytes into the IR,
// bumping the PC after each byte. Define FETCH_WAIT_STATE_EN for address-settle cycles.
module fetch_sequencer #(
   parameter logic [1:0] PC_SEL    = 2'b00,
   parameter logic [2:0] PC_REGSEL = 3'b100
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] IROut,
   input  logic        InstrReady,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic [2:0]  ARF_RegSel,
   output logic [1:0]  ARF_FunSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [15:0] Instr,
   output logic        InstrValid,
   output logic        Busy,
   output logic [15:0] FetchCount
);

`ifdef FETCH_WAIT_STATE_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_L = 3'd1,
      FETCH_H = 3'd2,
      VALID   = 3'd3,
      WAIT_L  = 3'd4,
      WAIT_H  = 3'd5
   } state_t;
   localparam state_t LOW_ENTRY  = WAIT_L;
   localparam state_t HIGH_ENTRY = WAIT_H;
`else
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH_L = 2'd1,
      FETCH_H = 2'd2,
      VALID   = 2'd3
   } state_t;
   localparam state_t LOW_ENTRY  = FETCH_L;
   localparam state_t HIGH_ENTRY = FETCH_H;
`endif

   localparam logic [2:0]  REGSEL_NONE = 3'b000;
   localparam logic [1:0]  FUN_HOLD    = 2'b00;
   localparam logic [1:0]  FUN_INC     = 2'b01;
   localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

   state_t      state_q, state_d;
   logic [15:0] fetchCount_q, fetchCount_d;
   logic        memCs_q, memCs_d;
   logic        irLh_q, irLh_d;
   logic        irWrite_q, irWrite_d;
   logic [2:0]  arfRegSel_q, arfRegSel_d;
   logic [1:0]  arfFunSel_q, arfFunSel_d;
   logic        instrValid_q, instrValid_d;
   logic        busy_q, busy_d;

   // Next state and handshake counter; Start is only looked at in IDLE and on handshake.
   always_comb begin
      state_d      = state_q;
      fetchCount_d = fetchCount_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = LOW_ENTRY;
            end
         end
`ifdef FETCH_WAIT_STATE_EN
         WAIT_L: begin
            state_d = FETCH_L;
         end
         WAIT_H: begin
            state_d = FETCH_H;
         end
`endif
         FETCH_L: begin
            state_d = HIGH_ENTRY;
         end
         FETCH_H: begin
            state_d = VALID;
         end
         VALID: begin
            if (InstrReady) begin
               state_d = Start ? LOW_ENTRY : IDLE;
               if (fetchCount_q != COUNT_MAX) begin
                  fetchCount_d = fetchCount_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so they leave the flops in step with it.
   always_comb begin
      memCs_d      = 1'b1;
      irLh_d       = 1'b0;
      irWrite_d    = 1'b0;
      arfRegSel_d  = REGSEL_NONE;
      arfFunSel_d  = FUN_HOLD;
      instrValid_d = 1'b0;
      busy_d       = (state_d != IDLE);
      case (state_d)
         FETCH_L: begin
            memCs_d     = 1'b0;
            irWrite_d   = 1'b1;
            arfRegSel_d = PC_REGSEL;
            arfFunSel_d = FUN_INC;
         end
         FETCH_H: begin
            memCs_d     = 1'b0;
            irLh_d      = 1'b1;
            irWrite_d   = 1'b1;
            arfRegSel_d = PC_REGSEL;
            arfFunSel_d = FUN_INC;
         end
`ifdef FETCH_WAIT_STATE_EN
         WAIT_L: begin
            memCs_d = 1'b0;
         end
         WAIT_H: begin
            memCs_d = 1'b0;
            irLh_d  = 1'b1;
         end
`endif
         VALID: begin
            instrValid_d = 1'b1;
         end
         default: begin
            memCs_d = 1'b1;
         end
      endcase
   end

   // Reset forces IDLE outputs straight out of the flops, so no increment or IR write follows it.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q      <= IDLE;
         fetchCount_q <= 16'h0000;
         memCs_q      <= 1'b1;
         irLh_q       <= 1'b0;
         irWrite_q    <= 1'b0;
         arfRegSel_q  <= REGSEL_NONE;
         arfFunSel_q  <= FUN_HOLD;
         instrValid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetchCount_q <= fetchCount_d;
         memCs_q      <= memCs_d;
         irLh_q       <= irLh_d;
         irWrite_q    <= irWrite_d;
         arfRegSel_q  <= arfRegSel_d;
         arfFunSel_q  <= arfFunSel_d;
         instrValid_q <= instrValid_d;
         busy_q       <= busy_d;
      end
   end

   assign Mem_CS      = memCs_q;
   assign Mem_WR      = 1'b0;
   assign IR_LH       = irLh_q;
   assign IR_Write    = irWrite_q;
   assign ARF_RegSel  = arfRegSel_q;
   assign ARF_FunSel  = arfFunSel_q;
   assign ARF_OutDSel = PC_SEL;
   assign InstrValid  = instrValid_q;
   assign Busy        = busy_q;
   assign FetchCount  = fetchCount_q;
   // The IR is written on the edge entering VALID, so the instruction is passed through live.
   assign Instr       = instrValid_q ? IROut : 16'h0000;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; adapts its expected latency when
// FETCH_WAIT_STATE_EN is defined.
module tb_fetch_sequencer;

   localparam logic [2:0] PC_REGSEL = 3'b100;
`ifdef FETCH_WAIT_STATE_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int PER = LAT + 1;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [15:0] IROut;
   logic        InstrReady;
   logic        Mem_CS;
   logic        Mem_WR;
   logic        IR_LH;
   logic        IR_Write;
   logic [2:0]  ARF_RegSel;
   logic [1:0]  ARF_FunSel;
   logic [1:0]  ARF_OutDSel;
   logic [15:0] Instr;
   logic        InstrValid;
   logic        Busy;
   logic [15:0] FetchCount;

   int total = 0;
   int bad   = 0;

   fetch_sequencer dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Start       (Start),
      .IROut       (IROut),
      .InstrReady  (InstrReady),
      .Mem_CS      (Mem_CS),
      .Mem_WR      (Mem_WR),
      .IR_LH       (IR_LH),
      .IR_Write    (IR_Write),
      .ARF_RegSel  (ARF_RegSel),
      .ARF_FunSel  (ARF_FunSel),
      .ARF_OutDSel (ARF_OutDSel),
      .Instr       (Instr),
      .InstrValid  (InstrValid),
      .Busy        (Busy),
      .FetchCount  (FetchCount)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic test_reset();
      Reset      = 1'b0;
      Start      = 1'b0;
      InstrReady = 1'b0;
      IROut      = 16'h0000;
      repeat (2) @(negedge Clock);
      total++;
      if ({Busy, InstrValid, Mem_CS, IR_Write} !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL reset_ctrl got=%b want=0010", {Busy, InstrValid, Mem_CS, IR_Write});
      end
      total++;
      if (FetchCount !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_count got=%h want=0000", FetchCount);
      end
      total++;
      if ({ARF_RegSel, ARF_FunSel, Mem_WR, ARF_OutDSel} !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_arf got=%b want=00000000", {ARF_RegSel, ARF_FunSel, Mem_WR, ARF_OutDSel});
      end
      Reset = 1'b1;
      @(negedge Clock);
      total++;
      if ({Busy, Mem_CS} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL reset_release got=%b want=01", {Busy, Mem_CS});
      end
   endtask

   task automatic test_single_fetch();
      int validAt;
      int incs;
      logic [15:0] seenInstr;
      validAt   = 0;
      incs      = 0;
      seenInstr = 16'h0000;
      Start      = 1'b1;
      InstrReady = 1'b1;
      IROut      = 16'hA55A;
      for (int c = 1; c <= PER + 2; c++) begin
         @(negedge Clock);
         Start = 1'b0;
         if (InstrValid === 1'b1 && validAt == 0) begin
            validAt   = c;
            seenInstr = Instr;
         end
         if (ARF_RegSel === PC_REGSEL && ARF_FunSel === 2'b01) incs++;
      end
      total++;
      if (validAt != LAT + 1) begin
         bad++;
         $display("[TB] FAIL single_latency got=%0d want=%0d", validAt, LAT + 1);
      end
      total++;
      if (seenInstr !== 16'hA55A) begin
         bad++;
         $display("[TB] FAIL single_instr got=%h want=a55a", seenInstr);
      end
      total++;
      if (incs != 2) begin
         bad++;
         $display("[TB] FAIL single_incs got=%0d want=2", incs);
      end
      total++;
      if ({Busy, FetchCount} !== {1'b0, 16'd1}) begin
         bad++;
         $display("[TB] FAIL single_end busy=%b count=%0d want busy=0 count=1", Busy, FetchCount);
      end
   endtask

   task automatic test_back_to_back();
      int handshakes;
      int writes;
      int csLow;
      int instrErr;
      logic [5:0] lhSeq;
      handshakes = 0;
      writes     = 0;
      csLow      = 0;
      instrErr   = 0;
      lhSeq      = 6'b000000;
      Start      = 1'b1;
      InstrReady = 1'b1;
      IROut      = 16'h1234;
      for (int c = 1; c <= 3 * PER; c++) begin
         @(negedge Clock);
         if (InstrValid === 1'b1) begin
            handshakes++;
            if (Instr !== 16'h1234) instrErr++;
         end
         if (IR_Write === 1'b1) begin
            writes++;
            lhSeq = {lhSeq[4:0], IR_LH};
         end
         if (Mem_CS === 1'b0) csLow++;
         if (c == 3 * PER) Start = 1'b0;
      end
      @(negedge Clock);
      total++;
      if (handshakes != 3) begin
         bad++;
         $display("[TB] FAIL b2b_handshakes got=%0d want=3", handshakes);
      end
      total++;
      if (writes != 6 || lhSeq !== 6'b010101) begin
         bad++;
         $display("[TB] FAIL b2b_irlh writes=%0d seq=%b want writes=6 seq=010101", writes, lhSeq);
      end
      total++;
      if (csLow != 3 * LAT) begin
         bad++;
         $display("[TB] FAIL b2b_cslow got=%0d want=%0d", csLow, 3 * LAT);
      end
      total++;
      if (instrErr != 0) begin
         bad++;
         $display("[TB] FAIL b2b_instr bad_cycles=%0d want=0", instrErr);
      end
      total++;
      if ({Busy, FetchCount} !== {1'b0, 16'd4}) begin
         bad++;
         $display("[TB] FAIL b2b_end busy=%b count=%0d want busy=0 count=4", Busy, FetchCount);
      end
   endtask

   task automatic test_stall();
      int violations;
      violations = 0;
      Start      = 1'b1;
      InstrReady = 1'b0;
      IROut      = 16'hBEEF;
      for (int c = 1; c <= PER; c++) begin
         @(negedge Clock);
         Start = 1'b0;
      end
      total++;
      if ({InstrValid, Instr} !== {1'b1, 16'hBEEF}) begin
         bad++;
         $display("[TB] FAIL stall_enter valid=%b instr=%h want valid=1 instr=beef", InstrValid, Instr);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         if (InstrValid !== 1'b1 || Mem_CS !== 1'b1 || IR_Write !== 1'b0 ||
             ARF_FunSel !== 2'b00 || FetchCount !== 16'd4) violations++;
      end
      total++;
      if (violations != 0) begin
         bad++;
         $display("[TB] FAIL stall_hold bad_cycles=%0d want=0", violations);
      end
      InstrReady = 1'b1;
      @(negedge Clock);
      InstrReady = 1'b0;
      total++;
      if ({Busy, InstrValid, FetchCount} !== {2'b00, 16'd5}) begin
         bad++;
         $display("[TB] FAIL stall_release busy=%b valid=%b count=%0d want 0 0 5", Busy, InstrValid, FetchCount);
      end
   endtask

   task automatic test_idle_ready();
      InstrReady = 1'b1;
      Start      = 1'b0;
      repeat (3) @(negedge Clock);
      InstrReady = 1'b0;
      total++;
      if ({Busy, InstrValid, FetchCount} !== {2'b00, 16'd5}) begin
         bad++;
         $display("[TB] FAIL idle_ready busy=%b valid=%b count=%0d want 0 0 5", Busy, InstrValid, FetchCount);
      end
   endtask

   task automatic test_reset_mid_fetch();
      int incs;
      logic [1:0] atHigh;
      incs       = 0;
      atHigh     = 2'b00;
      Start      = 1'b1;
      InstrReady = 1'b0;
      IROut      = 16'h0F0F;
      for (int c = 1; c <= LAT; c++) begin
         @(negedge Clock);
         Start = 1'b0;
         if (c == LAT) begin
            atHigh = {IR_Write, IR_LH};
            Reset  = 1'b0;
         end
         if (ARF_RegSel === PC_REGSEL && ARF_FunSel === 2'b01 && Reset === 1'b1) incs++;
      end
      @(negedge Clock);
      total++;
      if (atHigh !== 2'b11) begin
         bad++;
         $display("[TB] FAIL midreset_fetchh got=%b want=11", atHigh);
      end
      total++;
      if ({Busy, IR_Write, Mem_CS, ARF_FunSel} !== 5'b00100) begin
         bad++;
         $display("[TB] FAIL midreset_idle got=%b want=00100", {Busy, IR_Write, Mem_CS, ARF_FunSel});
      end
      total++;
      if (incs != 1) begin
         bad++;
         $display("[TB] FAIL midreset_incs got=%0d want=1", incs);
      end
      total++;
      if (FetchCount !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL midreset_count got=%0d want=0", FetchCount);
      end
      Reset = 1'b1;
      @(negedge Clock);
      total++;
      if ({Busy, InstrValid} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL midreset_after got=%b want=00", {Busy, InstrValid});
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_stall();
      test_idle_ready();
      test_reset_mid_fetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
